png_frame_ctrl: RTL and testbench
=================================

Name: png_frame_ctrl

Overview:
- Frame-level sequencer in front of the zlib/deflate bitstream writer.
- Accepts raw scanline bytes from the pixel source and prefixes each row with a PNG filter-type byte (0x00, "None").
- Forwards the resulting byte stream to the LZ77/Adler-32 front end and marks the final byte with a last flag.
- Pulses the bitstream writer's start, waits for its done, then reports frame completion and the raw byte count.

Parameters:
- ROW_WD, 16, width of the bytes-per-row configuration (row length excluding the filter byte).
- COL_WD, 16, width of the row-count configuration.
- CNT_WD, 32, width of the raw byte counter (filter bytes plus pixel bytes).
- BS_WARMUP, 3, cycles from the bs_start_o pulse to the first raw byte offered; covers the writer's header states.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  frame start request, single-cycle pulse
- abort_i  in  1  synchronous abort, returns to IDLE
- row_len_i  in  ROW_WD  pixel bytes per row; sampled on accepted start
- row_num_i  in  COL_WD  rows per frame; sampled on accepted start
- pix_val_i  in  1  source byte valid
- pix_dat_i  in  8  source byte
- pix_rdy_o  out  1  source byte accepted when pix_val_i & pix_rdy_o
- raw_val_o  out  1  byte valid toward LZ77/Adler-32
- raw_dat_o  out  8  byte toward LZ77/Adler-32
- raw_lst_o  out  1  qualifies raw_val_o; marks the final byte of the frame
- raw_rdy_i  in  1  downstream ready
- bs_start_o  out  1  start pulse to the bitstream writer
- bs_done_i  in  1  bitstream writer done pulse
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  frame-complete pulse, one cycle
- err_o  out  1  one-cycle pulse when start_i is rejected for a zero-sized frame
- raw_cnt_o  out  CNT_WD  bytes transferred in the current or last frame

Behaviour:
- Reset and interface:
  - Single clock clk. Reset rst is synchronous and active-high.
  - Reset values: all outputs 0, raw_cnt_o = 0, state IDLE.
- States: IDLE, WARM, FILT, ROW, WAIT_BS, DONE.
- IDLE:
  - start_i with row_len_i != 0 and row_num_i != 0: latch both values, clear raw_cnt_o, assert bs_start_o for exactly this cycle, go to WARM.
  - start_i with either value zero: err_o pulses next cycle and the state stays IDLE.
- WARM:
  - Counts BS_WARMUP-1 further cycles. raw_val_o = 0 and pix_rdy_o = 0.
  - Then go to FILT.
- FILT:
  - raw_val_o = 1, raw_dat_o = 0x00, pix_rdy_o = 0.
  - On raw_rdy_i: raw_cnt_o += 1, column counter cleared, go to ROW.
  - raw_lst_o = 0 always; a row never consists of the filter byte alone.
- ROW, combinational passthrough:
  - raw_val_o = pix_val_i, raw_dat_o = pix_dat_i, pix_rdy_o = raw_rdy_i.
  - Each transfer increments the column counter and raw_cnt_o.
  - raw_lst_o = 1 when column == row_len-1 and row == row_num-1.
  - On the transfer with column == row_len-1:
    - if row < row_num-1: row += 1, go to FILT;
    - else go to WAIT_BS.
- WAIT_BS:
  - No raw traffic and pix_rdy_o = 0.
  - On bs_done_i go to DONE.
  - bs_done_i in any other state is ignored.
- DONE: done_o = 1 for one cycle, go to IDLE. raw_cnt_o holds until the next accepted start.
- start_i while busy_o = 1 is ignored, with no err_o.
- abort_i:
  - Highest priority after rst, in any state: next state IDLE, no done_o, raw_cnt_o holds.
  - A transfer in the same cycle still counts.
- rst mid-frame: everything returns to reset values next cycle; no done_o.
- Arithmetic:
  - Row/column counters are ROW_WD/COL_WD bits and do not wrap, because termination compares against the latched values.
  - raw_cnt_o wraps mod 2^CNT_WD.
  - Expected frame total = row_num × (row_len + 1).
- Throughput: one byte per cycle when pix_val_i and raw_rdy_i are held high. There is one filter-byte bubble per row on the source side.

Decomposition:
- Shared package png_pkg:
  - state encodings;
  - FILT_NONE = 8'h00;
  - default widths ROW_WD, COL_WD, CNT_WD;
  - BS_WARMUP, which is tied to the bitstream writer's header state count.
- Single module, no sub-modules. The two counters are small enough to stay inline.

Test Plan:
- 3 bytes × 2 rows, source and sink always ready:
  - raw stream 00,a,b,c,00,d,e,f;
  - raw_lst_o only on f;
  - bs_start_o 3 cycles before the first 00;
  - done_o one cycle after bs_done_i;
  - raw_cnt_o = 8.
- Same frame with raw_rdy_i toggling every cycle and random pix_val_i gaps:
  - identical byte order, no byte lost or duplicated;
  - pix_rdy_o = 0 during FILT and WARM.
- 1 byte × 1 row:
  - stream 00,x with raw_lst_o on x;
  - WAIT_BS entered after x;
  - bs_done_i arriving 50 cycles later gives done_o.
- row_len_i = 0 with start_i: err_o pulses, busy_o stays 0, no bs_start_o. Repeat with row_num_i = 0: same result.
- abort_i during row 1 of a 4×3 frame:
  - IDLE next cycle, no done_o;
  - a new start_i then runs a clean frame with raw_cnt_o = 15.
- start_i during ROW and a stray bs_done_i during FILT: both ignored; the frame completes normally.

Source files
------------

// File: rtl/png_pkg.sv
// Shared types and constants for the PNG frame sequencer and its bitstream-writer neighbours.
package png_pkg;

  localparam int DEF_ROW_WD = 16;
  localparam int DEF_COL_WD = 16;
  localparam int DEF_CNT_WD = 32;

  // Matches the number of zlib header states the bitstream writer walks through after start.
  localparam int BS_WARMUP = 3;

  localparam logic [7:0] FILT_NONE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARM,
    ST_FILT,
    ST_ROW,
    ST_WAIT_BS,
    ST_DONE
  } state_t;

endpackage

// File: rtl/png_frame_ctrl_if.sv
// Byte-stream handshakes around the frame sequencer: pixel source in, raw bytes out to LZ77/Adler-32.
interface png_frame_ctrl_if;

  logic       pix_val_i;
  logic [7:0] pix_dat_i;
  logic       pix_rdy_o;

  logic       raw_val_o;
  logic [7:0] raw_dat_o;
  logic       raw_lst_o;
  logic       raw_rdy_i;

  modport master (
    input  pix_val_i, pix_dat_i, raw_rdy_i,
    output pix_rdy_o, raw_val_o, raw_dat_o, raw_lst_o
  );

  modport slave (
    output pix_val_i, pix_dat_i, raw_rdy_i,
    input  pix_rdy_o, raw_val_o, raw_dat_o, raw_lst_o
  );

endinterface

// File: rtl/png_frame_ctrl.sv
// Frame sequencer: prefixes each scanline with a filter byte and brackets the frame with writer start/done.
// Zero-latency passthrough in ROW; raw_rdy_i stalls the source directly, filter bytes cost one source bubble.
module png_frame_ctrl
  import png_pkg::*;
#(
  parameter int ROW_WD = DEF_ROW_WD,
  parameter int COL_WD = DEF_COL_WD,
  parameter int CNT_WD = DEF_CNT_WD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ROW_WD-1:0] row_len_i,
  input  logic [COL_WD-1:0] row_num_i,
  png_frame_ctrl_if.master  dp,
  output logic              bs_start_o,
  input  logic              bs_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_WD-1:0] raw_cnt_o
);

  localparam logic [7:0] WARM_LAST = 8'((BS_WARMUP > 1) ? BS_WARMUP - 2 : 0);

  state_t            state_q, state_d;
  logic [ROW_WD-1:0] row_len_q, col_q;
  logic [COL_WD-1:0] row_num_q, row_q;
  logic [7:0]        warm_q;
  logic              err_q;
  logic              idle_req, size_ok, start_ok, start_bad;
  logic              xfer, col_last, row_last;

  assign idle_req  = (state_q == ST_IDLE) && start_i && !abort_i && !rst;
  assign size_ok   = (row_len_i != '0) && (row_num_i != '0);
  assign start_ok  = idle_req && size_ok;
  assign start_bad = idle_req && !size_ok;

  // Termination compares against the latched sizes, so the counters never need to wrap.
  assign col_last = (col_q == row_len_q - ROW_WD'(1));
  assign row_last = (row_q == row_num_q - COL_WD'(1));

  assign busy_o = (state_q != ST_IDLE);
  assign err_o  = err_q;

  always_comb begin
    state_d      = state_q;
    dp.raw_val_o = 1'b0;
    dp.raw_dat_o = FILT_NONE;
    dp.raw_lst_o = 1'b0;
    dp.pix_rdy_o = 1'b0;
    xfer         = 1'b0;
    bs_start_o   = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          bs_start_o = 1'b1;
          state_d    = ST_WARM;
        end
      end
      ST_WARM: begin
        if (warm_q == WARM_LAST) state_d = ST_FILT;
      end
      ST_FILT: begin
        dp.raw_val_o = 1'b1;
        xfer         = dp.raw_rdy_i;
        if (dp.raw_rdy_i) state_d = ST_ROW;
      end
      ST_ROW: begin
        dp.raw_val_o = dp.pix_val_i;
        dp.raw_dat_o = dp.pix_dat_i;
        dp.pix_rdy_o = dp.raw_rdy_i;
        dp.raw_lst_o = dp.pix_val_i && col_last && row_last;
        xfer         = dp.pix_val_i && dp.raw_rdy_i;
        if (xfer && col_last) state_d = row_last ? ST_WAIT_BS : ST_FILT;
      end
      ST_WAIT_BS: begin
        if (bs_done_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_len_q <= '0;
      row_num_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      warm_q    <= '0;
      err_q     <= 1'b0;
      raw_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;

      if (start_ok) begin
        row_len_q <= row_len_i;
        row_num_q <= row_num_i;
        col_q     <= '0;
        row_q     <= '0;
        warm_q    <= '0;
        raw_cnt_o <= '0;
      end

      if (state_q == ST_WARM) warm_q <= warm_q + 8'd1;

      // A transfer coinciding with abort still counts.
      if (xfer) begin
        raw_cnt_o <= raw_cnt_o + CNT_WD'(1);
        if (state_q == ST_FILT) begin
          col_q <= '0;
        end else if (col_last) begin
          col_q <= '0;
          if (!row_last) row_q <= row_q + COL_WD'(1);
        end else begin
          col_q <= col_q + ROW_WD'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_png_frame_ctrl.sv
// Directed bench for png_frame_ctrl: frame streams, handshake stalls, zero-size rejects, abort and reset.
module tb_png_frame_ctrl;
  import png_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_i, abort_i, bs_done_i;
  logic [15:0] row_len_i, row_num_i;
  logic        bs_start_o, busy_o, done_o, err_o;
  logic [31:0] raw_cnt_o;

  png_frame_ctrl_if dp ();

  png_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .row_len_i (row_len_i),
    .row_num_i (row_num_i),
    .dp        (dp),
    .bs_start_o(bs_start_o),
    .bs_done_i (bs_done_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .raw_cnt_o (raw_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] cap_dat[$];
  logic       cap_lst[$];
  int cyc = 0;
  int bs_cnt, bs_cyc, first_cyc, lst_cyc, bsd_cyc, done_cyc, done_cnt, err_cnt, leak, post_lst;

  task automatic clr_mon();
    cap_dat.delete();
    cap_lst.delete();
    bs_cnt = 0; bs_cyc = -1; first_cyc = -1; lst_cyc = -1; bsd_cyc = -1;
    done_cyc = -1; done_cnt = 0; err_cnt = 0; leak = 0; post_lst = 0;
  endtask

  // Observe the handshakes mid-cycle, when inputs and combinational outputs are stable.
  always @(negedge clk) begin
    cyc++;
    if (dp.raw_val_o && dp.raw_rdy_i) begin
      cap_dat.push_back(dp.raw_dat_o);
      cap_lst.push_back(dp.raw_lst_o);
      if (dp.raw_lst_o) lst_cyc = cyc;
    end
    if (dp.raw_val_o && first_cyc < 0) first_cyc = cyc;
    if (lst_cyc >= 0 && cyc > lst_cyc && dp.raw_val_o && done_cnt == 0) post_lst++;
    if (bs_start_o) begin bs_cnt++; bs_cyc = cyc; end
    if (bs_done_i) bsd_cyc = cyc;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (err_o) err_cnt++;
    // A source byte accepted without being forwarded unchanged is lost.
    if (dp.pix_val_i && dp.pix_rdy_o && !(dp.raw_val_o && dp.raw_dat_o == dp.pix_dat_i)) leak++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; abort_i = 1'b0; bs_done_i = 1'b0;
    dp.pix_val_i = 1'b0; dp.pix_dat_i = 8'h00; dp.raw_rdy_i = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int rl, input int rn);
    logic [7:0] e[$];
    int bad = 0;
    int nl = 0;
    int lpos = -1;
    for (int r = 0; r < rn; r++) begin
      e.push_back(8'h00);
      for (int c = 0; c < rl; c++) e.push_back(8'(16 + r * rl + c));
    end
    chk({tag, "_len"}, 64'(cap_dat.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i >= cap_dat.size() || cap_dat[i] !== e[i]) bad++;
    chk({tag, "_bytes_wrong"}, 64'(bad), 64'd0);
    for (int i = 0; i < cap_lst.size(); i++)
      if (cap_lst[i]) begin nl++; lpos = i; end
    chk({tag, "_lst_count"}, 64'(nl), 64'd1);
    chk({tag, "_lst_pos"}, 64'(lpos), 64'(e.size() - 1));
  endtask

  // One frame: k counts cycles after the start cycle; abort_k < 0 means no abort.
  task automatic run_frame(input string tag, input int rl, input int rn, input bit tog,
                           input bit gaps, input int bs_dly, input int abort_k,
                           input bit noise, input int abort_cnt);
    int  idx = 0;
    int  n = rl * rn;
    int  since = 0;
    bit  acc = 1'b0;
    bit  seen = 1'b0;
    clr_mon();
    @(posedge clk); #1;
    row_len_i = 16'(rl); row_num_i = 16'(rn); start_i = 1'b1;
    dp.pix_val_i = 1'b0; dp.raw_rdy_i = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (acc) idx++;
      #1;
      start_i   = noise && (k == 4);
      if (noise && k == 4) row_len_i = 16'd1;
      bs_done_i = noise && (k == 2);
      abort_i   = (k == abort_k);
      dp.raw_rdy_i = tog ? k[0] : 1'b1;
      dp.pix_val_i = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
      dp.pix_dat_i = 8'(16 + idx);
      if (seen) begin
        since++;
        if (since == bs_dly) bs_done_i = 1'b1;
      end
      #1;
      acc = dp.pix_val_i && dp.pix_rdy_o;
      if (dp.raw_val_o && dp.raw_rdy_i && dp.raw_lst_o) seen = 1'b1;
      if (abort_k >= 0 && k == abort_k + 1) begin
        chk({tag, "_abort_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_abort_cnt"}, 64'(raw_cnt_o), 64'(abort_cnt));
      end
      if (abort_k >= 0 && k == abort_k + 3) break;
      if (done_o) break;
    end
    @(posedge clk); #1;
    idle_inputs();
    if (abort_k < 0) chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic err_case(input string tag, input int rl, input int rn);
    clr_mon();
    @(posedge clk); #1;
    row_len_i = 16'(rl); row_num_i = 16'(rn); start_i = 1'b1;
    #1;
    chk({tag, "_bs_start"}, 64'(bs_start_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    chk({tag, "_err"}, 64'(err_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    @(posedge clk); #2;
    chk({tag, "_err_clear"}, 64'(err_o), 64'd0);
    chk({tag, "_bs_cnt"}, 64'(bs_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; row_len_i = '0; row_num_i = '0;
    idle_inputs();
    dp.raw_rdy_i = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_cnt", 64'(raw_cnt_o), 64'd0);
    chk("rst_raw_val", 64'(dp.raw_val_o), 64'd0);
    chk("rst_pix_rdy", 64'(dp.pix_rdy_o), 64'd0);
    chk("rst_bs_start", 64'(bs_start_o), 64'd0);
    rst = 1'b0;
    dp.raw_rdy_i = 1'b1;

    // 3 bytes x 2 rows at full rate
    run_frame("f32", 3, 2, 1'b0, 1'b0, 1, -1, 1'b0, 0);
    check_stream("f32", 3, 2);
    chk("f32_warmup", 64'(first_cyc - bs_cyc), 64'd3);
    chk("f32_rate", 64'(lst_cyc - first_cyc), 64'd7);
    chk("f32_done_lat", 64'(done_cyc - bsd_cyc), 64'd1);
    chk("f32_cnt", 64'(raw_cnt_o), 64'd8);
    chk("f32_bs_cnt", 64'(bs_cnt), 64'd1);

    // same frame with sink toggling and source gaps
    run_frame("f32s", 3, 2, 1'b1, 1'b1, 3, -1, 1'b0, 0);
    check_stream("f32s", 3, 2);
    chk("f32s_leak", 64'(leak), 64'd0);
    chk("f32s_cnt", 64'(raw_cnt_o), 64'd8);

    // 1 x 1 with a slow writer
    run_frame("f11", 1, 1, 1'b0, 1'b0, 50, -1, 1'b0, 0);
    check_stream("f11", 1, 1);
    chk("f11_wait", 64'(done_cyc - lst_cyc), 64'd51);
    chk("f11_quiet", 64'(post_lst), 64'd0);
    chk("f11_cnt", 64'(raw_cnt_o), 64'd2);

    err_case("zero_len", 0, 2);
    err_case("zero_rows", 3, 0);

    // abort on the second byte of row 1 of a 4x3 frame, then a clean frame
    run_frame("abort", 4, 3, 1'b0, 1'b0, 1, 9, 1'b0, 8);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    run_frame("f43", 4, 3, 1'b0, 1'b0, 1, -1, 1'b0, 0);
    check_stream("f43", 4, 3);
    chk("f43_cnt", 64'(raw_cnt_o), 64'd15);

    // start during ROW and stray bs_done during FILT are ignored
    run_frame("noise", 3, 2, 1'b0, 1'b0, 1, -1, 1'b1, 0);
    check_stream("noise", 3, 2);
    chk("noise_bs_cnt", 64'(bs_cnt), 64'd1);
    chk("noise_err", 64'(err_cnt), 64'd0);
    chk("noise_cnt", 64'(raw_cnt_o), 64'd8);
    chk("noise_done_lat", 64'(done_cyc - bsd_cyc), 64'd1);

    // reset in the middle of a frame
    clr_mon();
    @(posedge clk); #1;
    row_len_i = 16'd3; row_num_i = 16'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; dp.pix_val_i = 1'b1; dp.pix_dat_i = 8'h10;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_before", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dp.pix_val_i = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_cnt", 64'(raw_cnt_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
